// File: rtl/checkbits_perf_monitor_if.sv
// Bundle of the checkbits monitor's bus-side signals: the firmware pad bus and
// clear go in, the measurement status and kcycle count come out.
interface checkbits_perf_monitor_if;
   logic [15:0] checkbits;
   logic        clear;
   logic        busy;
   logic        pass;
   logic        fail;
   logic        done;
   logic [31:0] kcycles;

   // Test harness / host side
   modport master (
      output checkbits,
      output clear,
      input  busy,
      input  pass,
      input  fail,
      input  done,
      input  kcycles
   );

   // Monitor side
   modport slave (
      input  checkbits,
      input  clear,
      output busy,
      output pass,
      output fail,
      output done,
      output kcycles
   );
endinterface

// File: rtl/checkbits_perf_monitor.sv
// Checkbits performance monitor: watches the firmware-driven checkbits pad bus,
// starts a kcycle measurement on START_CODE, ends it with pass on END_CODE and
// declares fail when the total time since reset/clear reaches TIMEOUT_K kcycles.
module checkbits_perf_monitor #(
   parameter logic [15:0] START_CODE   = 16'hA000,
   parameter logic [15:0] END_CODE     = 16'hAB00,
   parameter int unsigned CYCLES_PER_K = 1000,
   parameter int unsigned TIMEOUT_K    = 150,
   parameter int unsigned STABLE       = 2
) (
   input logic                     clock,
   input logic                     reset,
   checkbits_perf_monitor_if.slave mon
);

   localparam int unsigned SUB_W  = $clog2(CYCLES_PER_K);
   localparam int unsigned TOT_W  = $clog2(TIMEOUT_K + 1);
   localparam int unsigned STAB_W = $clog2(STABLE + 1);

   localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(CYCLES_PER_K - 1);
   localparam logic [TOT_W-1:0]  TOT_LAST  = TOT_W'(TIMEOUT_K - 1);
   localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   state_t            state;

   logic [15:0]       s1;
   logic [15:0]       s2;
   logic [15:0]       filt;
   logic [STAB_W-1:0] stab_cnt;
   logic [STAB_W-1:0] stab_nxt;
   logic              accept;
   logic              evt_start;
   logic              evt_end;

   logic [SUB_W-1:0]  run_sub;
   logic [31:0]       kcycles_q;

   logic [SUB_W-1:0]  tot_sub;
   logic [TOT_W-1:0]  tot_k;
   logic              tot_wrap;
   logic              timeout_hit;
   logic              counting;

   logic              busy_q;
   logic              pass_q;
   logic              fail_q;
   logic              done_q;

   // reset and clear share one effect; reset simply wins when both are high
   logic              restart;
   assign restart = reset | mon.clear;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [STAB_W-1:0] stab_inc(input logic [STAB_W-1:0] v);
      return (v >= STAB_MAX) ? STAB_MAX : v + STAB_W'(1);
   endfunction

   // Stability run length of the value s2 takes on this edge (s1 is that value),
   // plus the timeout-wrap decode used by the FSM.
   always_comb begin
      stab_nxt    = (s1 == s2) ? stab_inc(stab_cnt) : STAB_W'(1);
      accept      = (stab_nxt >= STAB_MAX);
      counting    = (state == IDLE) || (state == RUN);
      tot_wrap    = (tot_sub == SUB_MAX);
      timeout_hit = counting && tot_wrap && (tot_k == TOT_LAST);
   end

   // Two-flop synchronizer, stability filter and single-shot code events.
   always_ff @(posedge clock) begin
      if (restart) begin
         s1        <= 16'h0000;
         s2        <= 16'h0000;
         filt      <= 16'h0000;
         stab_cnt  <= '0;
         evt_start <= 1'b0;
         evt_end   <= 1'b0;
      end else begin
         s1        <= mon.checkbits;
         s2        <= s1;
         stab_cnt  <= stab_nxt;
         evt_start <= 1'b0;
         evt_end   <= 1'b0;
         if (accept) begin
            filt      <= s1;
            evt_start <= (s1 == START_CODE) && (filt != START_CODE);
            evt_end   <= (s1 == END_CODE)   && (filt != END_CODE);
         end
      end
   end

   // Free-running timeout counter; only restart clears it, start codes do not.
   always_ff @(posedge clock) begin
      if (restart) begin
         tot_sub <= '0;
         tot_k   <= '0;
      end else if (counting) begin
         if (tot_wrap) begin
            tot_sub <= '0;
            tot_k   <= tot_k + TOT_W'(1);
         end else begin
            tot_sub <= tot_sub + SUB_W'(1);
         end
      end
   end

   // Measurement FSM with registered status flags and the measured kcycle count.
   always_ff @(posedge clock) begin
      if (restart) begin
         state     <= IDLE;
         busy_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         done_q    <= 1'b0;
         run_sub   <= '0;
         kcycles_q <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (timeout_hit) begin
                  state  <= FAIL;
                  fail_q <= 1'b1;
                  done_q <= 1'b1;
               end else if (evt_start) begin
                  state     <= RUN;
                  busy_q    <= 1'b1;
                  run_sub   <= '0;
                  kcycles_q <= 32'd0;
               end
            end
            RUN: begin
               if (evt_end) begin
                  // end code beats a coincident timeout; kcycles freezes here
                  state  <= PASS;
                  busy_q <= 1'b0;
                  pass_q <= 1'b1;
                  done_q <= 1'b1;
               end else if (timeout_hit) begin
                  // timeout beats a coincident restart
                  state  <= FAIL;
                  busy_q <= 1'b0;
                  fail_q <= 1'b1;
                  done_q <= 1'b1;
               end else if (evt_start) begin
                  run_sub   <= '0;
                  kcycles_q <= 32'd0;
               end else if (run_sub == SUB_MAX) begin
                  run_sub   <= '0;
                  kcycles_q <= sat_inc32(kcycles_q);
               end else begin
                  run_sub <= run_sub + SUB_W'(1);
               end
            end
            PASS: state <= PASS;
            FAIL: state <= FAIL;
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               pass_q <= 1'b0;
               fail_q <= 1'b0;
            end
         endcase
      end
   end

   assign mon.busy    = busy_q;
   assign mon.pass    = pass_q;
   assign mon.fail    = fail_q;
   assign mon.done    = done_q;
   assign mon.kcycles = kcycles_q;

endmodule
